// File: rtl/screen_pkg.sv
// screen_pkg: TX states, LCD command bytes, ASCII constants and the "SCALE:" header table for screen_uart_ctrl
package screen_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  localparam logic [7:0] LCD_CMD = 8'hFE;
  localparam logic [7:0] LCD_HOME = 8'h80;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_Q = 8'h3F;
  localparam logic [7:0] HDR [9] = '{LCD_CMD, LCD_HOME, 8'h53, 8'h43, 8'h41, 8'h4C, 8'h45, 8'h3A, ASCII_0};
  function automatic logic [7:0] scale_digit(input logic [7:0] s);
    return (s >= 8'd1 && s <= 8'd9) ? ASCII_0 + s : ASCII_Q;
  endfunction
endpackage

// File: rtl/screen_fifo.sv
// screen_fifo: byte FIFO, ports clk/rst(async high)/push/din/pop -> dout(head)/full/empty/count, pointers wrap mod DEPTH
module screen_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, rd;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    wr = push && !full;
    rd = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    dout = mem_q[rd_ptr_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/screen_uart_ctrl.sv
// screen_uart_ctrl: host bytes + "SCALE:<d>" header on scale change -> FIFO -> UART tx (ports clk/reset/scale/in_data/in_valid -> in_ready/tx/busy/fifo_count; macro SCREEN_UART_PARITY_EN adds even parity)
module screen_uart_ctrl
  import screen_pkg::*;
#(
  parameter int CLK_DIV = 5208,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    scale,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] MAX_FILL = CW'(FIFO_DEPTH - 9);
  tx_state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, last_scale_q, last_scale_d, digit_q, digit_d;
  logic [3:0] idx_q, idx_d;
  logic seq_q, seq_d, rdy_q;
  logic full, empty, f_push, f_pop, start, bit_end, stop_last;
  logic [7:0] f_din, f_dout;
`ifdef SCREEN_UART_PARITY_EN
  logic par_q, par_d;
`endif
  screen_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(f_push), .din(f_din), .pop(f_pop),
    .dout(f_dout), .full(full), .empty(empty), .count(fifo_count)
  );
  always_comb begin
    start = !seq_q && scale != last_scale_q && scale != 8'd0 && fifo_count <= MAX_FILL;
    in_ready = rdy_q && !full && !seq_q && !start;
    f_push = seq_q || (in_valid && in_ready);
    f_din = !seq_q ? in_data : idx_q == 4'd8 ? digit_q : HDR[idx_q];
    seq_d = start || (seq_q && idx_q != 4'd8);
    idx_d = seq_q ? idx_q + 4'd1 : 4'd0;
    last_scale_d = start ? scale : last_scale_q;
    digit_d = start ? scale_digit(scale) : digit_q;
    bit_end = div_q == LAST_DIV;
    stop_last = bit_q == 3'(STOP_BITS - 1);
    f_pop = !empty && (state_q == TX_IDLE || (state_q == TX_STOP && bit_end && stop_last));
    div_d = (state_q == TX_IDLE || bit_end) ? '0 : div_q + DW'(1);
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
`ifdef SCREEN_UART_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      TX_IDLE: state_d = TX_IDLE;
      TX_START: state_d = bit_end ? TX_DATA : TX_START;
      TX_DATA: if (bit_end) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 3'd1;
`ifdef SCREEN_UART_PARITY_EN
        state_d = bit_q == 3'd7 ? TX_PARITY : TX_DATA;
`else
        state_d = bit_q == 3'd7 ? TX_STOP : TX_DATA;
`endif
      end
      TX_PARITY: state_d = bit_end ? TX_STOP : TX_PARITY;
      TX_STOP: if (bit_end) begin
        bit_d = stop_last ? 3'd0 : bit_q + 3'd1;
        state_d = stop_last ? TX_IDLE : TX_STOP;
      end
      default: state_d = TX_IDLE;
    endcase
    if (f_pop) begin
      sh_d = f_dout;
      state_d = TX_START;
`ifdef SCREEN_UART_PARITY_EN
      par_d = ^f_dout;
`endif
    end
    tx = state_q == TX_START ? 1'b0 :
         state_q == TX_DATA ? sh_q[0] :
`ifdef SCREEN_UART_PARITY_EN
         state_q == TX_PARITY ? par_q :
`endif
         1'b1;
    busy = state_q != TX_IDLE || !empty;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      div_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      last_scale_q <= '0;
      digit_q <= '0;
      idx_q <= '0;
      seq_q <= 1'b0;
      rdy_q <= 1'b0;
`ifdef SCREEN_UART_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      last_scale_q <= last_scale_d;
      digit_q <= digit_d;
      idx_q <= idx_d;
      seq_q <= seq_d;
      rdy_q <= 1'b1;
`ifdef SCREEN_UART_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_screen_uart_ctrl.sv
// tb_screen_uart_ctrl: directed bench with a UART receiver scoreboard for screen_uart_ctrl (CLK_DIV=4)
module tb_screen_uart_ctrl;
  localparam int CD = 4;
  localparam int FD = 16;
  localparam int SB = 1;
`ifdef SCREEN_UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = CD * (9 + SB + PB);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] scale = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic in_ready, tx, busy;
  logic [4:0] fifo_count;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] hdr [8] = '{8'hFE, 8'h80, 8'h53, 8'h43, 8'h41, 8'h4C, 8'h45, 8'h3A};
  always #5 clk = ~clk;
  screen_uart_ctrl #(.CLK_DIV(CD), .FIFO_DEPTH(FD), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .scale(scale), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push_hdr(input logic [7:0] s);
    foreach (hdr[i]) exp_q.push_back(hdr[i]);
    exp_q.push_back((s >= 8'd1 && s <= 8'd9) ? 8'h30 + s : 8'h3F);
  endtask
  task automatic run_seq(input logic [7:0] s, input string tag);
    int n;
    scale = s;
    push_hdr(s);
    #1;
    chk({tag, "_rdy_at_start"}, in_ready, 0);
    n = 0;
    do begin
      step;
      n++;
      if (n == 9) chk({tag, "_rdy_9th_push"}, in_ready, 0);
      if (n == 10) begin
        chk({tag, "_rdy_after_seq"}, in_ready, 1);
        chk({tag, "_count_after_seq"}, fifo_count, 8);
      end
    end while ((n < 3 || busy) && n < 5000);
    chk({tag, "_busy_cycles"}, n, 3 + 9 * FRAME);
  endtask
  initial begin
    logic [7:0] rb;
    logic ab;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && tx === 1'b0) begin
        ab = reset;
        repeat (CD / 2) @(posedge clk);
        #2;
        ab |= reset;
        if (!ab) chk("rx_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CD) @(posedge clk);
          #2;
          ab |= reset;
          rb[i] = tx;
        end
`ifdef SCREEN_UART_PARITY_EN
        repeat (CD) @(posedge clk);
        #2;
        ab |= reset;
        if (!ab) chk("rx_parity_bit", tx, ^rb);
`endif
        repeat (CD) @(posedge clk);
        #2;
        ab |= reset;
        if (!ab) begin
          chk("rx_stop_bit", tx, 1);
          chk("rx_byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("rx_byte", rb, exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    logic fb [12];
    logic [7:0] d;
    logic [4:0] prev, minc;
    logic inc, low_seen;
    int n;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", fifo_count, 0);
    repeat (3) step;
    chk("rst_in_ready_held", in_ready, 0);
    reset = 1'b0;
    step;
    chk("in_ready_after_reset", in_ready, 1);
    d = 8'hA5;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i + 1] = d[i];
    fb[9] = ^d;
    fb[9 + PB] = 1'b1;
    in_data = d;
    in_valid = 1'b1;
    exp_q.push_back(d);
    step;
    in_valid = 1'b0;
    chk("a5_count", fifo_count, 1);
    for (int i = 0; i < 9 + SB + PB; i++)
      for (int c = 0; c < CD; c++) begin
        step;
        chk($sformatf("a5_bit%0d_clk%0d", i, c), tx, fb[i]);
      end
    chk("a5_busy_in_stop", busy, 1);
    step;
    chk("a5_busy_fall", busy, 0);
    repeat (5) step;
    run_seq(8'd3, "s3");
    repeat (50) step;
    chk("s3_no_resend_busy", busy, 0);
    chk("s3_no_resend_count", fifo_count, 0);
    run_seq(8'd12, "s12");
    repeat (10) step;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && in_ready; i++) begin
      in_data = 8'(8'h60 + i);
      exp_q.push_back(in_data);
      step;
    end
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_count", fifo_count, 16);
    scale = 8'd6;
    prev = fifo_count;
    minc = fifo_count;
    inc = 1'b0;
    n = 0;
    do begin
      step;
      n++;
      if (n == 100) begin
        scale = 8'd5;
        push_hdr(8'd5);
      end
      if (!inc) begin
        if (fifo_count > prev) inc = 1'b1;
        else minc = fifo_count;
      end
      prev = fifo_count;
    end while (busy && n < 20000);
    chk("defer_seq_started", inc, 1);
    chk("defer_min_count", minc, 7);
    repeat (10) step;
    in_data = 8'h00;
    in_valid = 1'b1;
    exp_q.push_back(in_data);
    step;
    in_data = 8'h22;
    exp_q.push_back(in_data);
    step;
    in_valid = 1'b0;
    repeat (21) step;
    chk("abort_bit4_low", tx, 0);
    reset = 1'b1;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_count", fifo_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    exp_q.delete();
    scale = 8'd0;
    repeat (3) step;
    reset = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step;
      low_seen |= !tx;
    end
    chk("abort_no_frames", low_seen, 0);
    chk("abort_idle_busy", busy, 0);
`ifdef SCREEN_UART_PARITY_EN
    in_data = 8'h07;
    in_valid = 1'b1;
    exp_q.push_back(in_data);
    step;
    in_valid = 1'b0;
    repeat (38) step;
    chk("parity_07", tx, 1);
    repeat (4) step;
    chk("parity_07_stop", tx, 1);
    n = 0;
    while (busy && n < 1000) begin
      step;
      n++;
    end
    chk("parity_07_done", busy, 0);
`endif
    repeat (20) step;
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
